// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM response stage:
//   - load operation encodings carried on in_ld_op
//   - MEM entry state encoding
//   - width of the flushed-response cancel counter
// ---------------------------------------------------------------------------
package mem_pkg;

    // Load operation encodings. LD_D and LD_WU are only meaningful on a
    // 64-bit datapath.
    localparam logic [2:0] LD_B    = 3'd0;
    localparam logic [2:0] LD_H    = 3'd1;
    localparam logic [2:0] LD_W    = 3'd2;
    localparam logic [2:0] LD_D    = 3'd3;
    localparam logic [2:0] LD_BU   = 3'd4;
    localparam logic [2:0] LD_HU   = 3'd5;
    localparam logic [2:0] LD_WU   = 3'd6;
    localparam logic [2:0] LD_NONE = 3'd7;

    // MEM entry state.
    //   EMPTY : no instruction held
    //   WAIT  : load held, SRAM response not yet returned
    //   READY : final result available for WB
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } mem_state_e;

    // Counter wide enough to hold 0..max_cancel.
    function automatic int cancel_width(input int max_cancel);
        return $clog2(max_cancel + 1);
    endfunction

    localparam int MAX_CANCEL_DEFAULT = 3;
    localparam int CANCEL_W           = cancel_width(MAX_CANCEL_DEFAULT);

endpackage

// File: rtl/mem_load_align.sv
// ---------------------------------------------------------------------------
// mem_load_align
// Combinational load data aligner. Shifts the addressed bytes of an SRAM
// word down to bit 0 and sign- or zero-extends them according to ld_op.
//
// Ports:
//   data    in   DATA_W  raw SRAM response word
//   offset  in   OFF_W   byte offset of the access within the word
//   ld_op   in   3       load type (mem_pkg LD_* encodings)
//   result  out  DATA_W  aligned and extended load value
// ---------------------------------------------------------------------------
module mem_load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  offset,
    input  logic [2:0]        ld_op,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] word_sext;
    logic [DATA_W-1:0] word_zext;

    // The addressed byte becomes byte 0; offset is in bytes, so scale by 8.
    assign shifted = data >> {offset, 3'b000};

    // On a 32-bit datapath a word already fills the result, so both word
    // extensions collapse to a pass-through.
    generate
        if (DATA_W > 32) begin : g_wide_word
            assign word_sext = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
            assign word_zext = {{(DATA_W-32){1'b0}}, shifted[31:0]};
        end else begin : g_narrow_word
            assign word_sext = shifted;
            assign word_zext = shifted;
        end
    endgenerate

    always_comb begin
        result = shifted;
        case (ld_op)
            LD_B:    result = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            LD_BU:   result = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            LD_H:    result = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            LD_HU:   result = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            LD_W:    result = word_sext;
            LD_WU:   result = word_zext;
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_resp_stage.sv
// ---------------------------------------------------------------------------
// mem_resp_stage
// MEM pipeline stage with split-transaction data-SRAM responses. Holds the
// EX->MEM pipeline register, waits for the in-order load response, aligns
// and extends load data, drops responses belonging to flushed loads, and
// drives the MEM forwarding bus.
//
// Ports:
//   clk, reset                   clock, synchronous active-low reset
//   in_valid / in_ready          EX -> MEM handshake
//   in_pc, in_rf_we, in_rf_waddr instruction PC and register write info
//   in_ex_result                 ALU result / load effective address
//   in_mul, in_mul_result        multiplier select and product
//   in_req_issued                EX's load request was accepted by the SRAM
//   in_ld_op                     load type (mem_pkg LD_* encodings)
//   data_sram_data_ok/_rdata     in-order SRAM response
//   flush                        kill the MEM entry (exception / ertn)
//   out_valid / out_ready        MEM -> WB handshake
//   out_result, out_rf_we, out_rf_waddr, out_pc   to WB
//   byp_rf_we, byp_rf_waddr, byp_data_ok, byp_data forwarding bus
// ---------------------------------------------------------------------------
module mem_resp_stage
    import mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int MAX_CANCEL = 3
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_rf_we,
    input  logic [4:0]        in_rf_waddr,
    input  logic [DATA_W-1:0] in_ex_result,
    input  logic              in_mul,
    input  logic [DATA_W-1:0] in_mul_result,
    input  logic              in_req_issued,
    input  logic [2:0]        in_ld_op,

    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_rf_we,
    output logic [4:0]        out_rf_waddr,
    output logic [PC_W-1:0]   out_pc,

    output logic              byp_rf_we,
    output logic [4:0]        byp_rf_waddr,
    output logic              byp_data_ok,
    output logic [DATA_W-1:0] byp_data
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CW    = cancel_width(MAX_CANCEL);

    // -----------------------------------------------------------------------
    // Entry register and control state
    // -----------------------------------------------------------------------
    mem_state_e        state_reg, state_next;
    logic [CW-1:0]     cancel_cnt_reg, cancel_cnt_next;

    logic [PC_W-1:0]   pc_reg;
    logic              rf_we_reg;
    logic [4:0]        rf_waddr_reg;
    logic [DATA_W-1:0] ex_result_reg;
    logic              mul_reg;
    logic [DATA_W-1:0] mul_result_reg;
    logic [2:0]        ld_op_reg;
    logic              is_load_reg;
    logic [DATA_W-1:0] rbuf_reg;

    logic              cnt_zero;
    logic              deliver;
    logic              counted_ok;
    logic              cancel_inc;
    logic              fire;
    logic              accept;
    logic              in_is_load;

    logic [DATA_W-1:0] load_src;
    logic [DATA_W-1:0] load_aligned;

    assign cnt_zero   = (cancel_cnt_reg == '0);

    // A response belongs to the held load only when no flushed responses are
    // still ahead of it in the return stream.
    assign deliver    = (state_reg == WAIT) & data_sram_data_ok & cnt_zero;
    assign counted_ok = data_sram_data_ok & ~cnt_zero;

    // A flushed load whose response is not arriving right now still has one
    // in flight; remember to swallow it.
    assign cancel_inc = flush & (state_reg == WAIT) & ~deliver;

    assign out_valid  = (state_reg == READY) | deliver;
    assign fire       = out_valid & out_ready;
    assign in_ready   = (state_reg == EMPTY) | fire;
    assign accept     = in_valid & in_ready & ~flush;
    assign in_is_load = in_req_issued & (in_ld_op != LD_NONE);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = EMPTY;
        end else if (accept) begin
            state_next = in_is_load ? WAIT : READY;
        end else if (fire) begin
            // Covers both READY draining and a WAIT entry whose response is
            // consumed by WB in the same cycle it arrives.
            state_next = EMPTY;
        end else if (deliver) begin
            state_next = READY;
        end
    end

    // Increment and decrement in the same cycle cancel out. A count already
    // at MAX_CANCEL holds (and is flagged by the assertion below).
    always_comb begin
        cancel_cnt_next = cancel_cnt_reg;
        case ({cancel_inc, counted_ok})
            2'b10: begin
                if (cancel_cnt_reg != CW'(MAX_CANCEL)) begin
                    cancel_cnt_next = cancel_cnt_reg + CW'(1);
                end
            end
            2'b01:   cancel_cnt_next = cancel_cnt_reg - CW'(1);
            default: cancel_cnt_next = cancel_cnt_reg;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= EMPTY;
            cancel_cnt_reg <= '0;
            pc_reg         <= '0;
            rf_we_reg      <= 1'b0;
            rf_waddr_reg   <= '0;
            ex_result_reg  <= '0;
            mul_reg        <= 1'b0;
            mul_result_reg <= '0;
            ld_op_reg      <= LD_NONE;
            is_load_reg    <= 1'b0;
            rbuf_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            cancel_cnt_reg <= cancel_cnt_next;
            if (accept) begin
                pc_reg         <= in_pc;
                rf_we_reg      <= in_rf_we;
                rf_waddr_reg   <= in_rf_waddr;
                ex_result_reg  <= in_ex_result;
                mul_reg        <= in_mul;
                mul_result_reg <= in_mul_result;
                ld_op_reg      <= in_ld_op;
                is_load_reg    <= in_is_load;
            end
            // Raw data is kept so the result stays stable through WB stalls.
            if (deliver) begin
                rbuf_reg <= data_sram_rdata;
            end
        end
    end

    cancel_no_saturate: assert property (@(posedge clk) disable iff (!reset)
        !(cancel_inc && !counted_ok && (cancel_cnt_reg == CW'(MAX_CANCEL))));

    // -----------------------------------------------------------------------
    // Result path
    // -----------------------------------------------------------------------
    // In the arrival cycle rbuf is not written yet, so bypass the raw data.
    assign load_src = deliver ? data_sram_rdata : rbuf_reg;

    mem_load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_align (
        .data   (load_src),
        .offset (ex_result_reg[OFF_W-1:0]),
        .ld_op  (ld_op_reg),
        .result (load_aligned)
    );

    always_comb begin
        out_result = ex_result_reg;
        if (mul_reg) begin
            out_result = mul_result_reg;
        end else if (is_load_reg) begin
            out_result = load_aligned;
        end
    end

    assign out_rf_we    = rf_we_reg;
    assign out_rf_waddr = rf_waddr_reg;
    assign out_pc       = pc_reg;

    // -----------------------------------------------------------------------
    // Forwarding bus
    // -----------------------------------------------------------------------
    assign byp_rf_we    = rf_we_reg & (state_reg != EMPTY);
    assign byp_rf_waddr = rf_waddr_reg;
    assign byp_data_ok  = (state_reg == READY) | ((state_reg == WAIT) & out_valid);
    assign byp_data     = out_result;

endmodule

// File: doc/mem_resp_stage.md
# mem_resp_stage

Parametrised successor of the MEM pipeline stage. It holds the EX→MEM pipeline register and waits for split-transaction data-SRAM responses instead of assuming single-cycle read data. It aligns and extends loads of any supported width, and discards responses that belong to flushed instructions. It sits between EX (which issues requests) and WB, and drives the MEM forwarding bus.

## Interface
- DATA_W, 32, datapath and SRAM data width; 32 or 64.
- PC_W, 32, PC width.
- MAX_CANCEL, 3, maximum number of flushed-but-outstanding responses that can be tracked.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  EX holds a valid instruction with ready_go.
- in_ready  out  1  MEM allow-in.
- in_pc  in  PC_W  instruction PC.
- in_rf_we, in_rf_waddr  in  1, 5  register-file write enable and write address.
- in_ex_result  in  DATA_W  ALU result; for loads, the effective address.
- in_mul, in_mul_result  in  1, DATA_W  multiplier select and product.
- in_req_issued  in  1  EX's load request was accepted (addr_ok seen).
- in_ld_op  in  3  load type: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU, 7 none. Codes D and WU are legal only when DATA_W=64.
- data_sram_data_ok  in  1  response strobe; responses return in order.
- data_sram_rdata  in  DATA_W  response data.
- flush  in  1  exception or ertn from WB; kills the MEM entry.
- out_valid  out  1  result valid toward WB.
- out_ready  in  1  WB allow-in.
- out_result  out  DATA_W  final result.
- out_rf_we, out_rf_waddr, out_pc  out  1, 5, PC_W  passed through.
- byp_rf_we, byp_rf_waddr  out  1, 5  forwarding destination; byp_rf_we is gated by entry valid.
- byp_data_ok  out  1  0 while a load is still waiting; EX/ID must stall on a match when this is 0.
- byp_data  out  DATA_W  forwarded value.

## Operation
- States:
  - EMPTY: no entry.
  - WAIT: load entry, no data yet.
  - READY: result available.
- Accept: in_valid & in_ready & ~flush loads the entry register.
  - Next state is WAIT if in_req_issued and in_ld_op≠7; otherwise READY.
- WAIT → READY:
  - Occurs on data_sram_data_ok while cancel_cnt=0.
  - rdata is captured into rbuf in the same cycle.
  - While WAIT and data_ok are both high, out_result uses rdata combinationally.
- READY with out_ready:
  - Goes to EMPTY, or back to WAIT/READY if a new entry is accepted the same cycle.
- in_ready = (state==EMPTY) | (out_valid & out_ready).
- out_valid = (state==READY) | (state==WAIT & data_ok & cancel_cnt==0).
- Load alignment:
  - Byte offset is in_ex_result[log2(DATA_W/8)-1:0].
  - Signed ops (B/H/W) sign-extend to DATA_W; BU/HU/WU zero-extend; D passes through.
- Result priority: mul → mul_result; load → aligned data; otherwise ex_result.
- Flush:
  - Kills the entry and forces state to EMPTY; no accept in the same cycle.
  - If state was WAIT and data_ok is not high that cycle, cancel_cnt increments.
- Cancel counter:
  - While cancel_cnt>0, each data_ok decrements it and is never delivered.
  - A data_ok that arrives while the counter is nonzero and a new entry is waiting is consumed by the counter.
  - Flush and a counted data_ok in the same cycle leave the count unchanged.
  - Saturation at MAX_CANCEL is an assertion failure.
- Forwarding: byp_data = out_result; byp_data_ok = (state==READY) | (out_valid in WAIT).

## Timing
- Reset (reset=0 at a clk edge):
  - state=EMPTY, cancel_cnt=0, and all entry fields 0.
  - Outputs during reset: out_valid=0, byp_rf_we=0, in_ready=1, out_result=0.
- Non-load latency: accepted at edge N, out_valid high in cycle N+1.
- Load latency: out_valid high in the first cycle data_ok is seen with cancel_cnt=0; minimum is cycle N+1.
- WB stall: the result holds stable in rbuf; any number of stall cycles is allowed without losing data.
- Back-to-back: the stage accepts one entry per cycle when out_ready=1.
- Reset mid-WAIT: the counter clears, so the system must also reset the SRAM side.

## Structure
- Package mem_pkg holds:
  - the ld_op encodings;
  - the state enum {EMPTY, WAIT, READY};
  - CANCEL_W = $clog2(MAX_CANCEL+1).
- One sub-module: mem_load_align.
  - Combinational.
  - Inputs: DATA_W data, offset, ld_op.
  - Output: extended DATA_W value.

## Test plan
- ld.b at addr 0x...3, with rdata=0x80FF_1234 arriving 3 cycles after accept → out_result=0xFFFF_FF80 in the data_ok cycle; byp_data_ok is 0 for the prior cycles.
- ld.hu at addr 0x...2, with data_ok in the cycle after accept and rdata=0x9ABC_0000 → out_result=0x0000_9ABC; out_valid in cycle N+1.
- Load completes while out_ready=0 for 4 cycles → result holds 0x1234_5678 throughout; in_ready=0; WB accepts it once.
- Flush in WAIT, then a new load is accepted, then two data_ok pulses (0xDEAD, 0x0042) → the first is dropped with cancel_cnt 1→0; the delivered result is 0x0042.
- flush and data_ok in the same WAIT cycle → cancel_cnt stays 0; the next load gets its own response.
- With DATA_W=64: ld.wu at offset 4, rdata=0xF000_0001_0000_0000 → out_result=0x0000_0000_F000_0001.
